// File: rtl/cap_pkg.sv
// Shared state encoding and default sizing for the circular-buffer capture sequencer.
package cap_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ARMED,
        POST,
        DONE,
        DUMP
    } cap_state_t;

    localparam int ADDR_W_DEF   = 9;
    localparam int DEC_W_DEF    = 4;
    localparam int NUM_TRIG_DEF = 2;

endpackage

// File: rtl/dec_strobe.sv
// Decimation counter: pulses strobe once every 2**decimator cycles while run is high.
module dec_strobe #(
    parameter int DEC_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             run,
    input  logic [DEC_W-1:0] decimator,
    output logic             strobe
);

    localparam int CNT_W = (2 ** DEC_W) - 1;
    localparam logic [CNT_W-1:0] ONES = '1;

    logic [CNT_W-1:0] dec_cnt_reg;
    logic [CNT_W-1:0] term;

    // Terminal count is 2**decimator - 1: a mask of decimator low ones.
    assign term   = ~(ONES << decimator);
    assign strobe = run && (dec_cnt_reg == term);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_cnt_reg <= '0;
        end else if (clr) begin
            dec_cnt_reg <= '0;
        end else if (run) begin
            dec_cnt_reg <= strobe ? '0 : dec_cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/capture_ctrl.sv
// Circular-buffer capture sequencer: pre-trigger fill, armed wait, post-trigger count,
// done hold and ordered read-out of the channel RAMs starting at the oldest sample.
module capture_ctrl
    import cap_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DEC_W    = DEC_W_DEF,
    parameter int NUM_TRIG = NUM_TRIG_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                trig_en,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   trig_pos,
    input  logic [DEC_W-1:0]    decimator,
    input  logic [NUM_TRIG-1:0] trig,
    input  logic [NUM_TRIG-1:0] trig_mask,
    input  logic                force_trig,
    input  logic                clr_cap_done,
    input  logic                dump_req,
    input  logic                dump_adv,
    output logic                en,
    output logic                we,
    output logic [ADDR_W-1:0]   addr,
    output logic                armed,
    output logic                capture_done,
    output logic [ADDR_W-1:0]   trace_end,
    output logic                dump_vld,
    output logic                dump_last,
    output logic                busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    cap_state_t        state_reg;
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W-1:0] trace_end_reg;
    logic [ADDR_W-1:0] post_cnt_reg;
    logic [ADDR_W:0]   pre_cnt_reg;
    logic [ADDR_W:0]   rd_cnt_reg;
    logic              issue_reg;
    logic              wait_adv_reg;
    logic              vld_reg;
    logic              last_reg;

    logic              capturing;
    logic              wr_stb;
    logic              trig_hit;
    logic [ADDR_W:0]   pre_target;

    assign capturing  = (state_reg == PRE) || (state_reg == ARMED) || (state_reg == POST);
    assign trig_hit   = (|(trig & trig_mask)) | force_trig;
    assign pre_target = DEPTH_C - {1'b0, trig_pos};

    dec_strobe #(
        .DEC_W(DEC_W)
    ) u_dec_strobe (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (!capturing),
        .run       (capturing),
        .decimator (decimator),
        .strobe    (wr_stb)
    );

    assign en           = wr_stb | issue_reg;
    assign we           = wr_stb;
    assign addr         = (state_reg == DUMP) ? rd_ptr_reg : wr_ptr_reg;
    assign armed        = (state_reg == ARMED);
    assign capture_done = (state_reg == DONE) || (state_reg == DUMP);
    assign busy         = (state_reg != IDLE);
    assign trace_end    = trace_end_reg;
    assign dump_vld     = vld_reg;
    assign dump_last    = vld_reg & last_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            trace_end_reg <= '0;
            post_cnt_reg  <= '0;
            pre_cnt_reg   <= '0;
            rd_cnt_reg    <= '0;
            issue_reg     <= 1'b0;
            wait_adv_reg  <= 1'b0;
            vld_reg       <= 1'b0;
            last_reg      <= 1'b0;
        end else begin
            vld_reg <= issue_reg;
            if (wr_stb) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (trig_en) begin
                        state_reg    <= PRE;
                        wr_ptr_reg   <= '0;
                        pre_cnt_reg  <= '0;
                        post_cnt_reg <= '0;
                    end
                end
                PRE: begin
                    if (abort) begin
                        state_reg <= IDLE;
                    end else if (wr_stb) begin
                        pre_cnt_reg <= pre_cnt_reg + 1'b1;
                        if (pre_cnt_reg + 1'b1 == pre_target) begin
                            state_reg <= ARMED;
                        end
                    end
                end
                ARMED: begin
                    if (abort) begin
                        state_reg <= IDLE;
                    end else if (trig_hit) begin
                        if (trig_pos == '0) begin
                            // No post samples: the newest sample is this cycle's write, or the previous one.
                            state_reg     <= DONE;
                            trace_end_reg <= wr_stb ? wr_ptr_reg : wr_ptr_reg - 1'b1;
                        end else begin
                            state_reg <= POST;
                        end
                    end
                end
                POST: begin
                    if (abort) begin
                        state_reg <= IDLE;
                    end else if (wr_stb) begin
                        post_cnt_reg <= post_cnt_reg + 1'b1;
                        if (post_cnt_reg + 1'b1 == trig_pos) begin
                            state_reg     <= DONE;
                            trace_end_reg <= wr_ptr_reg;
                        end
                    end
                end
                DONE: begin
                    if (dump_req) begin
                        state_reg    <= DUMP;
                        rd_ptr_reg   <= trace_end_reg + 1'b1;
                        rd_cnt_reg   <= '0;
                        issue_reg    <= 1'b1;
                        wait_adv_reg <= 1'b0;
                        last_reg     <= 1'b0;
                    end else if (clr_cap_done) begin
                        state_reg <= IDLE;
                    end
                end
                DUMP: begin
                    if (issue_reg) begin
                        issue_reg    <= 1'b0;
                        wait_adv_reg <= 1'b1;
                        rd_ptr_reg   <= rd_ptr_reg + 1'b1;
                        rd_cnt_reg   <= rd_cnt_reg + 1'b1;
                        last_reg     <= (rd_cnt_reg == DEPTH_C - 1'b1);
                    end else if (wait_adv_reg && dump_adv) begin
                        wait_adv_reg <= 1'b0;
                        if (rd_cnt_reg == DEPTH_C) begin
                            state_reg <= DONE;
                        end else begin
                            issue_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl: write timeline derived arithmetically from the
// decimation ratio, pre/post sample counts and trigger cycle, plus read-out ordering checks.
module tb_capture_ctrl;

    localparam int ADDR_W   = 4;
    localparam int DEC_W    = 4;
    localparam int NUM_TRIG = 2;
    localparam int DEPTH    = 16;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                trig_en = 1'b0;
    logic                abort = 1'b0;
    logic [ADDR_W-1:0]   trig_pos = '0;
    logic [DEC_W-1:0]    decimator = '0;
    logic [NUM_TRIG-1:0] trig = '0;
    logic [NUM_TRIG-1:0] trig_mask = '0;
    logic                force_trig = 1'b0;
    logic                clr_cap_done = 1'b0;
    logic                dump_req = 1'b0;
    logic                dump_adv = 1'b0;
    logic                en, we, armed, capture_done, dump_vld, dump_last, busy;
    logic [ADDR_W-1:0]   addr, trace_end;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    capture_ctrl #(
        .ADDR_W  (ADDR_W),
        .DEC_W   (DEC_W),
        .NUM_TRIG(NUM_TRIG)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .trig_en     (trig_en),
        .abort       (abort),
        .trig_pos    (trig_pos),
        .decimator   (decimator),
        .trig        (trig),
        .trig_mask   (trig_mask),
        .force_trig  (force_trig),
        .clr_cap_done(clr_cap_done),
        .dump_req    (dump_req),
        .dump_adv    (dump_adv),
        .en          (en),
        .we          (we),
        .addr        (addr),
        .armed       (armed),
        .capture_done(capture_done),
        .trace_end   (trace_end),
        .dump_vld    (dump_vld),
        .dump_last   (dump_last),
        .busy        (busy)
    );

    task automatic check_idle_outputs(input string tag);
        n_checks++;
        if ({en, we, armed, capture_done, dump_vld, dump_last, busy} !== 7'b0 ||
            addr !== '0 || trace_end !== '0) begin
            n_fail++;
            $display("FAIL %s reset outputs: got en=%b we=%b armed=%b done=%b vld=%b last=%b busy=%b addr=%0d trace_end=%0d, expected all 0",
                     tag, en, we, armed, capture_done, dump_vld, dump_last, busy, addr, trace_end);
        end
    endtask

    task automatic test_reset();
        #12;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("after_reset_release");
        $display("reset: outputs checked while held and after release");
    endtask

    // Runs one capture. Cycle 0 is the first PRE cycle; the trigger lands in cycle
    // armed_start + toff. kind 0 uses the unmasked source, kind 1 uses force_trig.
    task automatic run_capture(input int dec, input int tp, input int toff, input int kind,
                               input logic [1:0] mask, input bit abrt, input int cut,
                               input string tag, output int te);
        int r, as, t, npre, done_c, stop;
        logic exp_we, exp_armed, exp_busy, exp_cd;
        logic [ADDR_W-1:0] exp_addr;
        r      = 1 << dec;
        as     = (DEPTH - tp) * r;
        t      = as + toff;
        npre   = (t + 1) / r;
        done_c = (tp == 0) ? t + 1 : (npre + tp) * r;
        stop   = abrt ? t + 1 : done_c;
        te     = (npre + tp - 1) % DEPTH;
        $display("capture %s: dec=%0d trig_pos=%0d mask=%b trigger@%0d abort=%0b done@%0d trace_end=%0d",
                 tag, dec, tp, mask, t, abrt, done_c, te);
        @(negedge clk);
        decimator = DEC_W'(dec);
        trig_pos  = ADDR_W'(tp);
        trig_mask = mask;
        trig_en   = 1'b1;
        @(negedge clk);
        trig_en = 1'b0;
        for (int k = 0; k <= stop + 1; k++) begin
            exp_we    = (k < stop) && (((k + 1) % r) == 0);
            exp_addr  = ADDR_W'((((k + 1) / r) - 1) % DEPTH);
            exp_armed = (k >= as) && (k <= t);
            exp_busy  = abrt ? (k <= t) : 1'b1;
            exp_cd    = !abrt && (k >= done_c);
            n_checks++;
            if (we !== exp_we || en !== exp_we) begin
                n_fail++;
                $display("FAIL %s we/en cycle %0d: got we=%b en=%b, expected %b", tag, k, we, en, exp_we);
            end
            if (exp_we) begin
                n_checks++;
                if (addr !== exp_addr) begin
                    n_fail++;
                    $display("FAIL %s write addr cycle %0d: got %0d, expected %0d", tag, k, addr, exp_addr);
                end
            end
            n_checks++;
            if (armed !== exp_armed || busy !== exp_busy || capture_done !== exp_cd) begin
                n_fail++;
                $display("FAIL %s status cycle %0d: got armed=%b busy=%b done=%b, expected armed=%b busy=%b done=%b",
                         tag, k, armed, busy, capture_done, exp_armed, exp_busy, exp_cd);
            end
            if (!abrt && k == done_c) begin
                n_checks++;
                if (trace_end !== ADDR_W'(te)) begin
                    n_fail++;
                    $display("FAIL %s trace_end: got %0d, expected %0d", tag, trace_end, te);
                end
            end
            if (k == cut) begin
                rst_n = 1'b0;
                #1;
                check_idle_outputs({tag, "_async_reset"});
                @(negedge clk);
                rst_n = 1'b1;
                $display("capture %s: async reset applied at cycle %0d", tag, k);
                return;
            end
            trig       = '0;
            force_trig = 1'b0;
            abort      = 1'b0;
            if (k == 0) begin
                trig       = mask;
                force_trig = 1'b1;
            end else if (k >= as && k < t) begin
                trig = ~mask;
            end else if (k == t) begin
                if (kind == 0) trig = mask;
                else force_trig = 1'b1;
                abort = abrt;
            end
            @(negedge clk);
        end
        trig       = '0;
        force_trig = 1'b0;
        abort      = 1'b0;
    endtask

    task automatic test_dump(input int te, input bit both, input string tag);
        logic [ADDR_W-1:0] exp_a;
        logic exp_last;
        int w;
        dump_req     = 1'b1;
        clr_cap_done = both;
        @(negedge clk);
        dump_req     = 1'b0;
        clr_cap_done = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            exp_a    = ADDR_W'((te + 1 + i) % DEPTH);
            exp_last = (i == DEPTH - 1);
            n_checks++;
            if (en !== 1'b1 || we !== 1'b0 || addr !== exp_a || dump_vld !== 1'b0) begin
                n_fail++;
                $display("FAIL %s read %0d: got en=%b we=%b addr=%0d vld=%b, expected en=1 we=0 addr=%0d vld=0",
                         tag, i, en, we, addr, dump_vld, exp_a);
            end
            @(negedge clk);
            n_checks++;
            if (dump_vld !== 1'b1 || dump_last !== exp_last || en !== 1'b0 || capture_done !== 1'b1) begin
                n_fail++;
                $display("FAIL %s vld %0d: got vld=%b last=%b en=%b done=%b, expected vld=1 last=%b en=0 done=1",
                         tag, i, dump_vld, dump_last, en, capture_done, exp_last);
            end
            w = $urandom_range(0, 2);
            for (int j = 0; j < w; j++) begin
                @(negedge clk);
                n_checks++;
                if (dump_vld !== 1'b0 || en !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s wait %0d: got vld=%b en=%b busy=%b, expected 0 0 1", tag, i, dump_vld, en, busy);
                end
            end
            dump_adv = 1'b1;
            @(negedge clk);
            dump_adv = 1'b0;
        end
        n_checks++;
        if (capture_done !== 1'b1 || busy !== 1'b1 || en !== 1'b0 || dump_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL %s back_to_done: got done=%b busy=%b en=%b vld=%b, expected 1 1 0 0",
                     tag, capture_done, busy, en, dump_vld);
        end
        $display("dump %s: %0d reads from addr %0d", tag, DEPTH, (te + 1) % DEPTH);
    endtask

    task automatic test_clear(input string tag);
        clr_cap_done = 1'b1;
        @(negedge clk);
        clr_cap_done = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || capture_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s clear: got busy=%b done=%b, expected 0 0", tag, busy, capture_done);
        end
        $display("clear %s: returned to idle", tag);
    endtask

    task automatic test_basic();
        int te;
        run_capture(0, 4, 8, 0, 2'b01, 1'b0, -1, "basic", te);
        test_dump(te, 1'b1, "basic");
        test_clear("basic");
    endtask

    task automatic test_decimate_force();
        int te;
        run_capture(2, 5, 6, 1, 2'b01, 1'b0, -1, "dec2_force", te);
        test_clear("dec2_force");
    endtask

    task automatic test_trig_pos_zero();
        int te;
        run_capture(0, 0, 3, 0, 2'b10, 1'b0, -1, "tp0_dec0", te);
        test_dump(te, 1'b0, "tp0_dec0");
        test_clear("tp0_dec0");
        run_capture(1, 0, 2, 1, 2'b11, 1'b0, -1, "tp0_dec1", te);
        test_clear("tp0_dec1");
    endtask

    task automatic test_abort();
        int te;
        run_capture(0, 3, 2, 0, 2'b11, 1'b1, -1, "abort_trig", te);
        run_capture(1, 7, 1, 1, 2'b01, 1'b1, -1, "abort_force", te);
    endtask

    task automatic test_async_reset();
        int te;
        run_capture(0, 6, 2, 0, 2'b01, 1'b0, 15, "rst_mid_post", te);
        run_capture(0, 2, 1, 0, 2'b01, 1'b0, -1, "after_rst", te);
        test_dump(te, 1'b0, "after_rst");
        test_clear("after_rst");
    endtask

    task automatic test_random();
        int te, dec, tp, toff, kind;
        logic [1:0] mask;
        for (int n = 0; n < 6; n++) begin
            dec  = $urandom_range(0, 2);
            tp   = $urandom_range(0, DEPTH - 1);
            toff = $urandom_range(0, 7);
            kind = $urandom_range(0, 1);
            mask = 2'($urandom_range(1, 3));
            run_capture(dec, tp, toff, kind, mask, 1'b0, -1, "random", te);
            if ($urandom_range(0, 1) == 1) test_dump(te, 1'b0, "random");
            test_clear("random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_decimate_force();
        test_trig_pos_zero();
        test_abort();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/capture_ctrl.md
# capture_ctrl

Parametrised successor to the single-channel-pair capture sequencer. It runs a circular-buffer acquisition: pre-trigger fill, armed wait, post-trigger count, done hold, then ordered read-out. It sits in the digital core between the command/config block and the channel RAMs. It drives the shared RAM address/enable/write-enable and a dump handshake toward the UART response path. Depth, decimation range and trigger-source count are generic, and it adds trigger masking, force-trigger, abort and wrapped dump ordering.

## Interface
- ADDR_W, 9: RAM address width; DEPTH = 2**ADDR_W samples.
- DEC_W, 4: decimator width; divide ratio is 2**decimator.
- NUM_TRIG, 2: number of trigger sources.

All signals use one clock; reset is asynchronous and active-low (`clk`, `rst_n`).
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- trig_en  in  1  start capture (sampled in IDLE only)
- abort  in  1  cancel capture, return to IDLE
- trig_pos  in  ADDR_W  samples to capture after trigger
- decimator  in  DEC_W  log2 sample divide
- trig  in  NUM_TRIG  trigger pulses from trigger logic
- trig_mask  in  NUM_TRIG  per-source enable
- force_trig  in  1  software trigger
- clr_cap_done  in  1  release DONE
- dump_req  in  1  start read-out (DONE only)
- dump_adv  in  1  consumer took current byte
- en  out  1  RAM enable
- we  out  1  RAM write enable
- addr  out  ADDR_W  RAM address
- armed  out  1  high in ARMED
- capture_done  out  1  high in DONE and DUMP
- trace_end  out  ADDR_W  address of last written sample
- dump_vld  out  1  RAM read data valid
- dump_last  out  1  qualifies final dump_vld
- busy  out  1  state != IDLE

## Operation
- States (`cap_state_t`): IDLE, PRE, ARMED, POST, DONE, DUMP.
- IDLE → PRE on `trig_en`. Entering PRE clears wr_ptr, the decimation counter, pre_cnt and post_cnt.
- Strobe: `dec_cnt` counts 0..(2**decimator)−1 in PRE/ARMED/POST. Strobe when dec_cnt equals the terminal value, then wrap to 0. decimator=0 gives a strobe every cycle. The counter width is (2**DEC_W)−1 bits.
- Write: on each strobe in PRE/ARMED/POST, `we=en=1`, `addr=wr_ptr`, and wr_ptr increments mod DEPTH (wraps DEPTH−1→0).
- PRE → ARMED after the write that makes pre_cnt = DEPTH−trig_pos. Triggers are ignored in PRE.
- Trigger = |(trig & trig_mask) | force_trig, accepted on any ARMED cycle. That cycle's write, if any, counts as pre-trigger.
- ARMED → POST on trigger. POST counts strobes; DONE follows the cycle after the trig_pos-th POST write.
- trig_pos=0: ARMED → DONE directly.
- On entering DONE, trace_end latches the last written address.
- DONE: `clr_cap_done` → IDLE; `dump_req` → DUMP. If both are asserted in the same cycle, dump wins. `trig_en` is ignored outside IDLE.
- DUMP: rd_ptr starts at trace_end+1 (mod DEPTH). The block issues `en=1, we=0, addr=rd_ptr` for one cycle; `dump_vld` pulses the next cycle.
- In DUMP, wait for `dump_adv`, then issue the next read. After DEPTH reads, `dump_last` accompanies the final dump_vld. The next `dump_adv` returns to DONE, so capture_done stays high.
- `abort` in PRE/ARMED/POST → IDLE. Abort beats a same-cycle trigger. Abort is ignored in DONE/DUMP.
- `trig_pos`, `decimator` and `trig_mask` are used live. Software changes them only in IDLE.

## Timing
- Reset values: en=we=armed=capture_done=dump_vld=dump_last=busy=0; addr=trace_end=0; state=IDLE.
- Outputs are decoded from registered state and pointers with no combinational path from trig/dump_adv to addr.
- Trigger to POST: 1 cycle.
- Last post write to capture_done: 1 cycle.
- dump_req to first read: 1 cycle. Read to dump_vld: 1 cycle (RAM latency).
- dump_adv to next read: 1 cycle.
- Async `rst_n` mid-capture or mid-dump returns to IDLE immediately. RAM contents are not cleared.

## Structure
- Package `cap_pkg`: `cap_state_t` enum plus shared default parameter constants.
- Sub-module `dec_strobe` (decimation counter with clear and strobe output) is instantiated once.
- The remaining logic (FSM, wr_ptr, rd_ptr, pre_cnt, post_cnt, dump counter) lives in `capture_ctrl`.

## Test plan
The bench uses ADDR_W=4 (DEPTH=16), NUM_TRIG=2.
- dec=0, trig_pos=4, trig_en at cycle 0, trig[0] with mask 01 at cycle 20 → addr0–11 written in PRE; armed from cycle 12; POST writes addr 5–8 in cycles 21–24; capture_done at cycle 25; trace_end=8.
- DUMP after the previous case → reads addr 9,10,…,15,0,…,8 (16 dump_vld); dump_last on the read of addr 8; capture_done remains 1; clr_cap_done → IDLE, busy=0.
- dec=2 → we pulses every 4th cycle; first write at PRE cycle 3; trig[1] masked off → no trigger; force_trig → POST.
- trig_pos=0 → DONE one cycle after trigger; trace_end = address written in the trigger cycle.
- abort in the same cycle as trigger in ARMED → IDLE, capture_done stays 0; trigger in PRE is ignored.
- rst_n low mid-POST → all outputs return to reset values asynchronously; trig_en afterward restarts at addr 0.
